// File: rtl/picorv_ahb_pkg.sv
// AHB-lite encodings, slave FSM state type and little-endian byte-lane decode.
// ST_WAIT only exists when PICORV_AHB_SRAM_WAIT_EN is defined.
package picorv_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
`ifdef PICORV_AHB_SRAM_WAIT_EN
        ST_WAIT = 3'd4,
`endif
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
    } aphase_t;

    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << lo;
            HSIZE_HALF: byte_lanes = lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/picorv_ahb_sram_array.sv
// Single-port 32-bit word SRAM with per-byte write enables.
// Read data registered one cycle after en with we==0; writes land on the same edge.
// No backpressure: one access per cycle, caller arbitrates the port.
module picorv_ahb_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000)
                rdata <= mem[addr];
            for (int b = 0; b < 4; b++)
                if (we[b])
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule

// File: rtl/picorv_ahb_sram_slave.sv
// AHB-lite SRAM slave with range/alignment checking; wait states via PICORV_AHB_SRAM_WAIT_EN.
// Read data one cycle after the accepted address (plus WAIT_STATES when enabled).
// Backpressure through o_hreadyout: low in WAIT and ERR1, high otherwise.
module picorv_ahb_sram_slave
    import picorv_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hreadyout,
    output logic [1:0]  o_hresp
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_e        state_q, nstate;
    aphase_t       ph_q;
    logic [32:0]   off33;
    logic          legal, take, rd_port, commit, rd_dphase;
    logic [AW-1:0] ph_idx, fwd_idx, arr_addr;
    logic [3:0]    ph_lanes, fwd_lanes, arr_we;
    logic [31:0]   fwd_dat, arr_rdata, arr_wdata, merged, hrdata_q;
    logic          fwd_vld, pend, arr_en;
    logic          unused_ok;

    assign off33 = {1'b0, i_haddr} - {1'b0, BASE_ADDR};

    always_comb begin
        legal = (off33 < SPAN);
        case (i_hsize)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (i_haddr[0]) legal = 1'b0;
            HSIZE_WORD: if (i_haddr[1:0] != 2'b00) legal = 1'b0;
            default:    legal = 1'b0;
        endcase
    end

    assign take      = i_hsel & i_htrans[1] & i_hready & (state_q == ST_IDLE || state_q == ST_DATA);
    assign rd_port   = take & legal & ~i_hwrite;
    assign commit    = (state_q == ST_DATA) & ph_q.write;
    assign rd_dphase = (state_q == ST_DATA) & ~ph_q.write;
    assign ph_idx    = word_idx(ph_q.addr);
    assign ph_lanes  = byte_lanes(ph_q.size, ph_q.addr[1:0]);

`ifdef PICORV_AHB_SRAM_WAIT_EN
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    logic [2:0] cnt_q;

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n)
            cnt_q <= 3'd0;
        else if (state_q != ST_WAIT && nstate == ST_WAIT)
            cnt_q <= WS;
        else if (state_q == ST_WAIT)
            cnt_q <= cnt_q - 3'd1;
    end

    assign unused_ok = ^{i_hburst, i_htrans[0]};
`else
    assign unused_ok = ^{i_hburst, i_htrans[0], 3'(WAIT_STATES)};
`endif

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
        end else begin
            state_q <= nstate;
            if (take)
                ph_q <= '{addr: i_haddr, size: i_hsize, write: i_hwrite};
        end
    end

    always_comb begin
        nstate = state_q;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (!take)
                    nstate = ST_IDLE;
                else if (!legal)
                    nstate = ST_ERR1;
`ifdef PICORV_AHB_SRAM_WAIT_EN
                else if (WS != 3'd0)
                    nstate = ST_WAIT;
`endif
                else
                    nstate = ST_DATA;
            end
`ifdef PICORV_AHB_SRAM_WAIT_EN
            ST_WAIT: if (cnt_q == 3'd1) nstate = ST_DATA;
`endif
            ST_ERR1: nstate = ST_ERR2;
            ST_ERR2: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = HRESP_OKAY;
        case (state_q)
`ifdef PICORV_AHB_SRAM_WAIT_EN
            ST_WAIT: o_hreadyout = 1'b0;
`endif
            ST_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = HRESP_ERROR;
            end
            ST_ERR2: o_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // A read address phase owns the port; a write colliding with it parks in the
    // forward register and drains on the next free cycle, which always arrives
    // before the next write's data phase (its address phase leaves the port idle).
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 4'b0000;
        arr_addr  = word_idx(i_haddr);
        arr_wdata = i_hwdata;
        if (rd_port) begin
            arr_en = 1'b1;
        end else if (commit) begin
            arr_en   = 1'b1;
            arr_we   = ph_lanes;
            arr_addr = ph_idx;
        end else if (pend) begin
            arr_en    = 1'b1;
            arr_we    = fwd_lanes;
            arr_addr  = fwd_idx;
            arr_wdata = fwd_dat;
        end
    end

    always_comb begin
        merged = arr_rdata;
        if (fwd_vld && fwd_idx == ph_idx)
            for (int b = 0; b < 4; b++)
                if (fwd_lanes[b])
                    merged[8*b +: 8] = fwd_dat[8*b +: 8];
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            fwd_vld   <= 1'b0;
            pend      <= 1'b0;
            fwd_idx   <= '0;
            fwd_lanes <= 4'b0000;
            fwd_dat   <= 32'd0;
            hrdata_q  <= 32'd0;
        end else begin
            if (commit) begin
                fwd_vld   <= 1'b1;
                fwd_idx   <= ph_idx;
                fwd_lanes <= ph_lanes;
                fwd_dat   <= i_hwdata;
                pend      <= rd_port;
            end else if (!rd_port) begin
                pend <= 1'b0;
            end
            if (rd_dphase)
                hrdata_q <= merged;
        end
    end

    assign o_hrdata = rd_dphase ? merged : hrdata_q;

    picorv_ahb_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (i_hclk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule
